// File: rtl/sdram_pattern_tester_if.sv
// Avalon-MM bus between the pattern tester (master) and the SDRAM
// controller slave port. The tester instance names its port sdram_1, so the
// members read as sdram_1.address, sdram_1.read_n and so on.
interface sdram_pattern_tester_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable_n;
  logic              chipselect;
  logic [DATA_W-1:0] writedata;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address,
    output byteenable_n,
    output chipselect,
    output writedata,
    output read_n,
    output write_n,
    input  readdata,
    input  readdatavalid,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  byteenable_n,
    input  chipselect,
    input  writedata,
    input  read_n,
    input  write_n,
    output readdata,
    output readdatavalid,
    output waitrequest
  );

endinterface

// File: rtl/sdram_pattern_tester.sv
// SDRAM bring-up / soak tester. On start it writes an address-derived
// pattern over a word range, reads the range back with up to MAX_PENDING
// reads in flight, and reports how many words came back wrong and the
// address of the first bad word. All bus outputs are registered so a
// stalled command is held simply by not touching the registers.
module sdram_pattern_tester #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  sdram_pattern_tester_if.master sdram_1
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] cmd_cnt;
  logic [ADDR_W-1:0] cmp_cnt;
  logic [ADDR_W-1:0] cmp_addr;
  logic [PEND_W-1:0] pending;

  logic              cmd_accept;
  logic              rd_accept;
  logic              rsp_valid;
  logic              rsp_mismatch;
  logic              last_cmd;
  logic              last_cmp;
  logic              issue_ok;
  logic [PEND_W-1:0] pending_next;
  logic [ADDR_W-1:0] next_addr;

  // The pattern is the zero-extended word address XORed with the seed, so
  // every word differs and a stuck or aliased address line shows up.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] s);
    return {{(DATA_W-ADDR_W){1'b0}}, a} ^ s;
  endfunction

  assign sdram_1.byteenable_n = 4'b0000;

  // Handshake decode, outstanding-read bookkeeping and the compare result.
  // Read data that arrives with nothing outstanding (e.g. after a reset
  // mid-test) is discarded here, so it never reaches the compare.
  always_comb begin
    cmd_accept   = sdram_1.chipselect & ~sdram_1.waitrequest;
    rd_accept    = cmd_accept && (state == ST_READ);
    rsp_valid    = sdram_1.readdatavalid && (pending != '0) &&
                   ((state == ST_READ) || (state == ST_DRAIN));
    rsp_mismatch = rsp_valid && (sdram_1.readdata != pat(cmp_addr, seed_q));
    last_cmd     = (cmd_cnt == len_q - 1'b1);
    last_cmp     = (cmp_cnt == len_q - 1'b1);
    next_addr    = sdram_1.address + 1'b1;
    pending_next = pending;
    if (rd_accept && !rsp_valid) begin
      pending_next = pending + PEND_W'(1);
    end else if (!rd_accept && rsp_valid) begin
      pending_next = pending - PEND_W'(1);
    end
    issue_ok     = (pending_next < PEND_MAX);
  end

  // Test sequencer: owns the state, the registered bus command, the
  // counters and the error result.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state              <= ST_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_count          <= 16'h0000;
      first_err_addr     <= '0;
      base_q             <= '0;
      len_q              <= '0;
      seed_q             <= '0;
      cmd_cnt            <= '0;
      cmp_cnt            <= '0;
      cmp_addr           <= '0;
      pending            <= '0;
      sdram_1.chipselect <= 1'b0;
      sdram_1.read_n     <= 1'b1;
      sdram_1.write_n    <= 1'b1;
      sdram_1.address    <= '0;
      sdram_1.writedata  <= '0;
    end else begin
      done    <= 1'b0;
      pending <= pending_next;

      if (rsp_valid) begin
        cmp_addr <= cmp_addr + 1'b1;
        cmp_cnt  <= cmp_cnt + 1'b1;
        if (rsp_mismatch) begin
          if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h0001;
          end
          if (err_count == 16'h0000) begin
            first_err_addr <= cmp_addr;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            busy           <= 1'b1;
            err_count      <= 16'h0000;
            first_err_addr <= '0;
            cmd_cnt        <= '0;
            cmp_cnt        <= '0;
            cmp_addr       <= base_addr;
            pending        <= '0;
            if (length == '0) begin
              // Nothing to test: the empty-range check in DRAIN fires on the
              // next cycle, which lands done two cycles after start.
              state <= ST_DRAIN;
            end else begin
              state              <= ST_WRITE;
              sdram_1.chipselect <= 1'b1;
              sdram_1.write_n    <= 1'b0;
              sdram_1.address    <= base_addr;
              sdram_1.writedata  <= pat(base_addr, seed);
            end
          end
        end

        ST_WRITE: begin
          if (cmd_accept) begin
            cmd_cnt <= cmd_cnt + 1'b1;
            if (last_cmd) begin
              // First read goes out immediately; nothing is pending yet.
              state           <= ST_READ;
              cmd_cnt         <= '0;
              sdram_1.write_n <= 1'b1;
              sdram_1.read_n  <= 1'b0;
              sdram_1.address <= base_q;
            end else begin
              sdram_1.address   <= next_addr;
              sdram_1.writedata <= pat(next_addr, seed_q);
            end
          end
        end

        ST_READ: begin
          if (cmd_accept) begin
            cmd_cnt         <= cmd_cnt + 1'b1;
            sdram_1.address <= next_addr;
            if (last_cmd) begin
              state              <= ST_DRAIN;
              sdram_1.chipselect <= 1'b0;
              sdram_1.read_n     <= 1'b1;
            end else begin
              sdram_1.chipselect <= issue_ok;
              sdram_1.read_n     <= ~issue_ok;
            end
          end else if (!sdram_1.chipselect) begin
            // Throttled by the outstanding limit; a stalled command is
            // left alone so it is never withdrawn.
            sdram_1.chipselect <= issue_ok;
            sdram_1.read_n     <= ~issue_ok;
          end
        end

        ST_DRAIN: begin
          if ((rsp_valid && last_cmp) || ((pending == '0) && (cmp_cnt == len_q))) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a randomized Avalon slave with memory,
// configurable waitrequest rate and read latency, plus a reference model
// that predicts the address sequence, data, error count and done timing.
module tb_sdram_pattern_tester;

  localparam int ADDR_W      = 25;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy;
  logic              done;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  sdram_pattern_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sdram_1 ();

  sdram_pattern_tester #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .seed(seed),
    .busy(busy),
    .done(done),
    .err_count(err_count),
    .first_err_addr(first_err_addr),
    .sdram_1(sdram_1)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                ready;
  } rsp_t;

  int                total = 0;
  int                bad = 0;
  rsp_t              rsp_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] corrupt_q[$];
  int                outstanding = 0;
  bit                reset_hit = 1'b0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s);
    return {7'd0, a} ^ s;
  endfunction

  function automatic bit is_corrupt(input logic [ADDR_W-1:0] a);
    foreach (corrupt_q[i]) if (corrupt_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ctrl"},
                 64'({busy, done, sdram_1.chipselect, sdram_1.read_n, sdram_1.write_n, sdram_1.byteenable_n}),
                 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000}));
    check_output({tag, "_err"}, 64'(err_count), 64'd0);
    check_output({tag, "_first"}, 64'(first_err_addr), 64'd0);
    check_output({tag, "_addr"}, 64'(sdram_1.address), 64'd0);
    check_output({tag, "_wdata"}, 64'(sdram_1.writedata), 64'd0);
  endtask

  // Reset while reads are in flight, keep returning their data, and make
  // sure the tester stays idle and ignores it.
  task automatic do_mid_reset(input int lat);
    reset_hit   = 1'b1;
    reset_reset = 1'b1;
    sdram_1.waitrequest   = 1'b0;
    sdram_1.readdatavalid = 1'b0;
    #1;
    check_reset_values("mid_reset");
    for (int k = 0; k < lat + 4; k++) begin
      @(negedge clk_clk);
      check_output("late_rsp_quiet",
                   64'({done, busy, sdram_1.chipselect, err_count}), 64'(0));
      if (k == 1) reset_reset = 1'b0;
      if (rsp_q.size() > 0) begin
        sdram_1.readdatavalid = 1'b1;
        sdram_1.readdata      = rsp_q.pop_front().data ^ 32'h0000_00FF;
      end else begin
        sdram_1.readdatavalid = 1'b0;
      end
    end
    sdram_1.readdatavalid = 1'b0;
    rsp_q.delete();
    outstanding = 0;
    @(negedge clk_clk);
  endtask

  task automatic run_test(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                          input logic [DATA_W-1:0] s, input int wait_pct,
                          input int lat, input int reset_pend);
    int                t;
    int                last_valid;
    int                wr_seen;
    int                rd_seen;
    int                exp_err;
    int                budget;
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [59:0]       prev_bus;
    logic [59:0]       cur_bus;
    bit                stalled;
    bit                expect_read;
    bit                got_done;
    bit                wr;

    exp_err   = 0;
    exp_first = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + ADDR_W'(i);
      if (is_corrupt(a)) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end

    @(negedge clk_clk);
    base_addr = b;
    length    = n;
    seed      = s;
    start     = 1'b1;
    @(negedge clk_clk);
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    length    = ADDR_W'($urandom);
    seed      = $urandom;

    t           = 1;
    last_valid  = 0;
    wr_seen     = 0;
    rd_seen     = 0;
    stalled     = 1'b0;
    expect_read = 1'b0;
    got_done    = 1'b0;
    prev_bus    = '0;
    budget      = 1000 + int'(n) * (lat + 4) * 2;
    outstanding = 0;
    rsp_q.delete();

    check_output("busy_after_start", 64'(busy), 64'd1);
    if (n != '0) check_output("first_cmd", 64'({sdram_1.chipselect, sdram_1.write_n}), 64'(2'b10));

    while (1) begin
      cur_bus = {sdram_1.chipselect, sdram_1.read_n, sdram_1.write_n, sdram_1.address, sdram_1.writedata};
      if (stalled) check_output("hold", 64'(cur_bus), 64'(prev_bus));
      if (expect_read) check_output("wr_to_rd", 64'({sdram_1.chipselect, sdram_1.read_n}), 64'(2'b10));
      expect_read = 1'b0;
      if (outstanding == MAX_PENDING) check_output("cs_at_max", 64'(sdram_1.chipselect), 64'd0);

      if (reset_pend > 0 && outstanding == reset_pend && wr_seen == int'(n) && rd_seen < int'(n)) begin
        do_mid_reset(lat);
        return;
      end

      if (done) begin
        got_done = 1'b1;
        check_output("done_time", 64'(t), 64'((n == '0) ? 2 : last_valid + 1));
        check_output("busy_at_done", 64'(busy), 64'd1);
        check_output("rsp_left", 64'(rsp_q.size()), 64'd0);
        break;
      end

      if (t > budget) begin
        check_output("timeout", 64'd1, 64'd0);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        break;
      end

      wr = ($urandom_range(99) < wait_pct);
      sdram_1.waitrequest = wr;
      if (sdram_1.chipselect && !wr) begin
        check_output("one_cmd", 64'({sdram_1.read_n, sdram_1.write_n} == 2'b00), 64'd0);
        if (!sdram_1.write_n) begin
          a = b + ADDR_W'(wr_seen);
          check_output("wr_addr", 64'(sdram_1.address), 64'(a));
          check_output("wr_data", 64'(sdram_1.writedata), 64'(ref_pat(a, s)));
          check_output("extra_write", 64'(wr_seen < int'(n)), 64'd1);
          mem[sdram_1.address] = sdram_1.writedata;
          wr_seen++;
          if (wr_seen == int'(n)) expect_read = 1'b1;
        end else if (!sdram_1.read_n) begin
          a = b + ADDR_W'(rd_seen);
          check_output("rd_addr", 64'(sdram_1.address), 64'(a));
          check_output("rd_after_wr", 64'(wr_seen), 64'(n));
          check_output("extra_read", 64'(rd_seen < int'(n)), 64'd1);
          d = mem.exists(sdram_1.address) ? mem[sdram_1.address] : 32'hDEAD_BEEF;
          if (is_corrupt(sdram_1.address)) d = d ^ 32'h0000_0001;
          rsp_q.push_back('{data: d, ready: t + lat});
          rd_seen++;
          outstanding++;
        end
      end
      stalled  = sdram_1.chipselect && wr;
      prev_bus = cur_bus;

      if (rsp_q.size() > 0 && rsp_q[0].ready <= t) begin
        sdram_1.readdatavalid = 1'b1;
        sdram_1.readdata      = rsp_q.pop_front().data;
        outstanding--;
        last_valid = t;
      end else begin
        sdram_1.readdatavalid = 1'b0;
        sdram_1.readdata      = $urandom;
      end
      if (outstanding > MAX_PENDING) check_output("pending_max", 64'(outstanding), 64'(MAX_PENDING));

      @(negedge clk_clk);
      t++;
    end

    sdram_1.readdatavalid = 1'b0;
    sdram_1.waitrequest   = 1'b0;
    if (got_done) begin
      check_output("err_count", 64'(err_count), 64'(exp_err));
      check_output("first_err", 64'(first_err_addr), 64'(exp_first));
      check_output("writes", 64'(wr_seen), 64'(n));
      check_output("reads", 64'(rd_seen), 64'(n));
      @(negedge clk_clk);
      check_output("done_pulse", 64'({done, busy, sdram_1.chipselect}), 64'd0);
      check_output("err_stable", 64'({err_count, first_err_addr}), 64'({16'(exp_err), exp_first}));
    end
  endtask

  initial begin
    sdram_1.readdata      = '0;
    sdram_1.readdatavalid = 1'b0;
    sdram_1.waitrequest   = 1'b0;
    repeat (3) @(negedge clk_clk);
    check_reset_values("reset");
    reset_reset = 1'b0;
    @(negedge clk_clk);

    $display("[TB] clean run");
    run_test(25'd0, 25'd16, 32'hA5A5_0000, 0, 3, 0);

    $display("[TB] backpressure");
    run_test(ADDR_W'($urandom), 25'd64, $urandom, 50, $urandom_range(1, 6), 0);

    $display("[TB] pending limit");
    run_test(25'd100, 25'd40, $urandom, 0, 20, 0);

    $display("[TB] error injection");
    corrupt_q = '{25'd5, 25'd9};
    run_test(25'd0, 25'd16, 32'hA5A5_0000, 0, 3, 0);
    corrupt_q.delete();

    $display("[TB] wrap");
    run_test(25'h1FF_FFFE, 25'd4, $urandom, 0, 2, 0);

    $display("[TB] length zero");
    run_test(25'd77, 25'd0, $urandom, 0, 3, 0);

    $display("[TB] reset mid-test");
    run_test(25'd0, 25'd64, $urandom, 0, 20, 5);
    check_output("reset_reached", 64'(reset_hit), 64'd1);
    run_test(25'd0, 25'd24, $urandom, 20, 4, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 4; r++) begin
      logic [ADDR_W-1:0] rb;
      logic [ADDR_W-1:0] rn;
      rb = ADDR_W'($urandom);
      rn = ADDR_W'($urandom_range(1, 40));
      corrupt_q.delete();
      if (r[0]) begin
        for (int k = 0; k < 3; k++) corrupt_q.push_back(rb + ADDR_W'($urandom_range(0, int'(rn) - 1)));
      end
      run_test(rb, rn, $urandom, $urandom_range(0, 60), $urandom_range(1, 12), 0);
    end
    corrupt_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
